// File: rtl/srl_fifo_pkg.sv
// rtl/srl_fifo_pkg.sv - shared constants, count width helper and count type for the SRL FIFO
package srl_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 6;
  localparam int DEPTH_DEF      = 63;
  localparam int AF_THRESH_DEF  = 60;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int COUNT_W_DEF = count_width(DEPTH_DEF);

  typedef logic [COUNT_W_DEF-1:0] count_t;

endpackage

// File: rtl/srl_fifo_store.sv
// rtl/srl_fifo_store.sv - shift-register word array with a registered read port
module srl_fifo_store
  import srl_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] dout
);

  generate
    if (DEPTH > 1) begin : g_srl
      // Newest word always lands at index 0; older words move up by one.
      logic [DATA_WIDTH-1:0] mem [DEPTH-1];

      always_ff @(posedge clk) begin
        if (we) begin
          mem[0] <= din;
          for (int i = 1; i < DEPTH-1; i++) begin
            mem[i] <= mem[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          dout <= '0;
        end else if (re) begin
          dout <= mem[raddr];
        end
      end
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (reset) begin
          dout <= '0;
        end else if (re) begin
          dout <= din;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/srl_fifo_ctrl.sv
// rtl/srl_fifo_ctrl.sv - valid/ready FIFO sequencing one SRL store plus its output register
// Optional protocol checker on err: define SRL_FIFO_PROTO_CHK_EN.
module srl_fifo_ctrl
  import srl_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int AF_THRESH  = AF_THRESH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  err
);

  localparam int MW = count_width(DEPTH);

  logic [MW-1:0]         mem_cnt, mem_cnt_next;
  logic [MW-1:0]         count_q, count_next;
  logic                  out_valid, out_valid_next;
  logic                  s_ready_q, s_ready_next;
  logic                  active, push, load;
  logic [ADDR_WIDTH-1:0] raddr;

  // No handshake may complete while reset is applied.
  assign active = clk_en & ~reset;
  assign push   = active & s_valid & s_ready_q;
  assign load   = (DEPTH > 1) ? (active & (mem_cnt != '0) & (~out_valid | m_ready)) : push;
  assign raddr  = (DEPTH > 1) ? ADDR_WIDTH'(mem_cnt - MW'(1)) : '0;

  always_comb begin
    mem_cnt_next   = mem_cnt;
    s_ready_next   = s_ready_q;
    out_valid_next = load | (out_valid & ~m_ready);
    if (DEPTH > 1) begin
      mem_cnt_next = mem_cnt + MW'(push) - MW'(load);
      s_ready_next = (mem_cnt_next != MW'(DEPTH-1));
    end else begin
      s_ready_next = ~out_valid_next;
    end
    count_next = mem_cnt_next + MW'(out_valid_next);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_cnt   <= '0;
      out_valid <= 1'b0;
      s_ready_q <= 1'b0;
      count_q   <= '0;
    end else if (clk_en) begin
      if (flush) begin
        mem_cnt   <= '0;
        out_valid <= 1'b0;
        s_ready_q <= 1'b1;
        count_q   <= '0;
      end else begin
        mem_cnt   <= mem_cnt_next;
        out_valid <= out_valid_next;
        s_ready_q <= s_ready_next;
        count_q   <= count_next;
      end
    end
  end

  assign s_ready     = s_ready_q;
  assign m_valid     = out_valid;
  assign count       = (ADDR_WIDTH+1)'(count_q);
  assign almost_full = (count_q >= MW'(AF_THRESH));

  srl_fifo_store #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_store (
    .clk  (clk),
    .reset(reset),
    .we   (push),
    .din  (s_data),
    .re   (load),
    .raddr(raddr),
    .dout (m_data)
  );

`ifdef SRL_FIFO_PROTO_CHK_EN
  logic                  stall_q;
  logic [DATA_WIDTH-1:0] held_q;
  logic                  err_q;

  // A stalled word must stay offered and unchanged until it is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= 1'b0;
      held_q  <= '0;
      err_q   <= m_ready;
    end else if (clk_en) begin
      stall_q <= s_valid & ~s_ready_q;
      held_q  <= s_data;
      if (stall_q && (!s_valid || s_data != held_q)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// tb/tb_srl_fifo_ctrl.sv - scoreboard bench for srl_fifo_ctrl
`timescale 1ns/1ps
module tb_srl_fifo_ctrl;
  import srl_fifo_pkg::*;

  localparam int DW    = DATA_WIDTH_DEF;
  localparam int AW    = ADDR_WIDTH_DEF;
  localparam int DEPTH = DEPTH_DEF;
  localparam int AFT   = AF_THRESH_DEF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clk_en = 1'b1;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          m_ready = 1'b0;
  logic          s_ready, m_valid, almost_full, err;
  logic [DW-1:0] m_data;
  logic [AW:0]   count;

  srl_fifo_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .AF_THRESH(AFT)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .almost_full(almost_full), .err(err)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic          stream_chk = 1'b0;
  logic          prev_reset = 1'b1;
  logic          armed = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] next_word = 32'h1000_0000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: occupancy equals words accepted minus words delivered; data leaves in push order.
  always begin
    @(posedge clk);
    #2;
    if (prev_reset) begin
      check("rst_count", count, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_s_ready", s_ready, 0);
      check("rst_almost_full", almost_full, 0);
      check("rst_m_data", m_data, 0);
      check("rst_err", err, 0);
    end else begin
      check("count", count, sb.size());
      check("almost_full", almost_full, sb.size() >= AFT);
      check("s_ready", s_ready, armed ? (sb.size() < DEPTH) : 1'b0);
      check("valid_implies_data", m_valid && sb.size() == 0, 0);
      if (prev_stall) begin
        check("stall_m_valid", m_valid, 1);
        check("stall_m_data", m_data, prev_data);
      end
      if (stream_chk) begin
        check("stream_m_valid", m_valid, 1);
        check("stream_count", count, 2);
      end
`ifndef SRL_FIFO_PROTO_CHK_EN
      check("err_tied", err, 0);
`endif
    end
    prev_stall = 1'b0;
    if (reset) begin
      sb.delete();
      armed = 1'b0;
    end else begin
      if (clk_en && m_valid && m_ready) begin
        if (sb.size() == 0) fail_now("pop_underflow");
        else check("m_data_order", m_data, sb.pop_front());
      end
      prev_stall = m_valid && !(clk_en && m_ready) && !(clk_en && flush);
      prev_data  = m_data;
      if (clk_en && flush) sb.delete();
      if (clk_en) armed = 1'b1;
    end
    prev_reset = reset;
  end

  // One cycle of stimulus: called at edge+1, logs an accepted word, returns at next edge+1.
  task automatic step(output bit hs);
    #3;
    hs = !reset && clk_en && s_valid && s_ready;
    if (hs && !flush) sb.push_back(s_data);
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    bit hs;
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = d;
    do begin
      step(hs);
      t++;
    end while (!hs && t < 200);
    if (!hs) fail_now("push_timeout");
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit hs;
    for (int i = 0; i < n; i++) step(hs);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    flush   = 1'b0;
    clk_en  = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hs;
    int acc;
    @(posedge clk);
    #1;
    do_reset();
    check("s_ready_before_en", s_ready, 0);
    idle(1);
    check("s_ready_after_reset", s_ready, 1);

    // Single word latency
    m_ready = 1'b1;
    push_word(32'hA5A5_0001);
    check("lat_valid_1", m_valid, 0);
    idle(1);
    check("lat_valid_2", m_valid, 1);
    check("lat_data", m_data, 32'hA5A5_0001);
    idle(3);
    check("single_drained", count, 0);

    // Fill to capacity with backpressure, then drain in order
    m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_word(DW'(i));
    idle(1);
    check("full_count", count, DEPTH);
    check("full_af", almost_full, 1);
    check("full_s_ready", s_ready, 0);
    m_ready = 1'b1;
    idle(DEPTH + 5);
    check("drain_count", count, 0);

    // Sustained streaming
    acc = 0;
    s_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (i == 4) stream_chk = 1'b1;
      s_data = next_word;
      step(hs);
      if (hs) begin
        acc++;
        next_word++;
      end
    end
    stream_chk = 1'b0;
    s_valid = 1'b0;
    check("stream_accepted", acc, 200);
    idle(4);

    // Random backpressure and clock enable
    for (int i = 0; i < 500; i++) begin
      if (!s_valid && ($urandom_range(0, 2) != 0)) begin
        s_valid = 1'b1;
        s_data  = next_word;
        next_word++;
      end
      m_ready = ($urandom_range(0, 1) == 1);
      clk_en  = ($urandom_range(0, 7) != 0);
      step(hs);
      if (hs) s_valid = 1'b0;
    end
    clk_en  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 100 && s_valid; i++) begin
      step(hs);
      if (hs) s_valid = 1'b0;
    end
    if (s_valid) fail_now("random_tail_timeout");
    s_valid = 1'b0;
    idle(DEPTH + 5);
    check("random_drained", count, 0);

    // Flush with a simultaneous push
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_word(32'h100 + DW'(i));
    idle(1);
    check("pre_flush_count", count, 10);
    flush   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    step(hs);
    flush   = 1'b0;
    s_valid = 1'b0;
    check("flush_count", count, 0);
    check("flush_m_valid", m_valid, 0);
    check("flush_s_ready", s_ready, 1);
    push_word(32'h55);
    m_ready = 1'b1;
    idle(1);
    check("post_flush_first", m_data, 32'h55);
    idle(3);
    check("post_flush_drained", count, 0);

`ifdef SRL_FIFO_PROTO_CHK_EN
    // Stalled word changes before acceptance
    m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_word(32'h200 + DW'(i));
    s_valid = 1'b1;
    s_data  = 32'h1;
    idle(2);
    check("proto_err_clear", err, 0);
    s_data = 32'h2;
    idle(1);
    check("proto_err_set", err, 1);
    idle(3);
    check("proto_err_sticky", err, 1);
    do_reset();
    check("proto_err_reset", err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
